mem_dump_monitor: RTL

Synthesizable run monitor for the single-cycle MIPS core. Watches the fetch PC until a parametrised end address is reached, or until a cycle budget expires. Then it holds the core and streams a parametrised window of data-memory words out over a valid/ready port. It replaces the fixed end-PC watch and RAM dump done by the fib bench, so that long programs and FPGA runs can be checked in hardware.

---
 rtl/mips_dbg_pkg.sv | 23 ++
 rtl/mem_dump_monitor_if.sv | 32 +++
 rtl/dump_sequencer.sv | 82 ++++++++
 rtl/mem_dump_monitor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared definitions for the MIPS run/dump debug logic.
// Contents:
//   state_e          - run monitor state encoding
//   DefaultEndPc     - PC marking completion of the fib program
//   DefaultDumpBase  - first data-memory word holding fib results
//   DefaultDumpCount - number of fib result words
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StRd,
    StWait,
    StOut,
    StDone,
    StTout
  } state_e;

  localparam logic [31:0] DefaultEndPc     = 32'h44;
  localparam int unsigned DefaultDumpBase  = 16;
  localparam int unsigned DefaultDumpCount = 15;

endpackage

// File: rtl/mem_dump_monitor_if.sv
// mem_dump_monitor_if: data-memory read port plus dump stream of the run monitor.
// Signals:
//   dmem_addr/dmem_re  - word address and read strobe (monitor -> memory)
//   dmem_rdata         - registered read data, valid one cycle after dmem_re
//   dump_data/index    - streamed word and its index (monitor -> sink)
//   dump_valid/ready   - stream handshake
// Modports: master (monitor side), slave (memory + sink side).
interface mem_dump_monitor_if #(
  parameter int unsigned DMEM_AW = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = 4
);

  logic [DMEM_AW-1:0] dmem_addr;
  logic               dmem_re;
  logic [DATA_W-1:0]  dmem_rdata;
  logic [DATA_W-1:0]  dump_data;
  logic [IDX_W-1:0]   dump_index;
  logic               dump_valid;
  logic               dump_ready;

  modport master (
    output dmem_addr, dmem_re, dump_data, dump_index, dump_valid,
    input  dmem_rdata, dump_ready
  );

  modport slave (
    input  dmem_addr, dmem_re, dump_data, dump_index, dump_valid,
    output dmem_rdata, dump_ready
  );

endinterface

// File: rtl/dump_sequencer.sv
// dump_sequencer: steps the dump index through RD/WAIT/OUT and runs the stream handshake.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   state        - current monitor state (owned by the top)
//   bus          - memory read port and dump stream (master side)
//   hs           - handshake this cycle (OUT and dump_ready)
//   last         - current index is the final word
//   checksum     - running sum of handshaken words (only with DUMP_CHECKSUM_EN)
module dump_sequencer
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DMEM_AW    = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DUMP_BASE  = DefaultDumpBase,
  parameter int unsigned DUMP_COUNT = DefaultDumpCount,
  parameter int unsigned IDX_W      = $clog2(DUMP_COUNT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  state_e              state,
  mem_dump_monitor_if.master  bus,
  output logic                hs,
  output logic                last
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam logic [IDX_W-1:0]   LastIdx  = IDX_W'(DUMP_COUNT - 1);
  localparam logic [DMEM_AW-1:0] BaseAddr = DMEM_AW'(DUMP_BASE);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign hs   = (state == StOut) && bus.dump_ready;
  assign last = (idx_q == LastIdx);

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    if (state == StWait) begin
      data_d = bus.dmem_rdata;
    end
    // Index stays on the final word once the dump completes.
    if (hs && !last) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  // Address wraps modulo 2^DMEM_AW; gated so the port reads zero outside RD.
  assign bus.dmem_re    = (state == StRd);
  assign bus.dmem_addr  = bus.dmem_re ? (BaseAddr + DMEM_AW'(idx_q)) : '0;
  assign bus.dump_valid = (state == StOut);
  assign bus.dump_data  = data_q;
  assign bus.dump_index = idx_q;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (hs) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: rtl/mem_dump_monitor.sv
// mem_dump_monitor: watches the fetch PC for END_PC or a cycle budget, then holds the core
// and streams DUMP_COUNT data-memory words starting at DUMP_BASE.
// Optional feature macro: DUMP_CHECKSUM_EN adds the checksum output.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   pc, pc_valid - core fetch PC and core-running flag
//   cpu_hold     - stall request, high from end detection until reset
//   bus          - memory read port and dump stream (master side)
//   cycle_count  - cycles spent in RUN, frozen after leaving RUN
//   done         - dump complete (sticky)
//   timeout      - budget expired without end match (sticky)
//   checksum     - sum of handshaken dump words (DUMP_CHECKSUM_EN only)
module mem_dump_monitor
  import mips_dbg_pkg::*;
#(
  parameter logic [31:0] END_PC     = DefaultEndPc,
  parameter int unsigned DMEM_AW    = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DUMP_BASE  = DefaultDumpBase,
  parameter int unsigned DUMP_COUNT = DefaultDumpCount,
  parameter int unsigned TIMEOUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  pc_valid,
  output logic                  cpu_hold,
  mem_dump_monitor_if.master    bus,
  output logic [TIMEOUT_W-1:0]  cycle_count,
  output logic                  done,
  output logic                  timeout
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  localparam int unsigned          IdxW   = $clog2(DUMP_COUNT + 1);
  localparam logic [TIMEOUT_W-1:0] CntMax = '1;

  if (DUMP_COUNT < 1) begin : g_bad_count
    $error("DUMP_COUNT must be at least 1");
  end

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 end_match;
  logic                 seq_hs;
  logic                 seq_last;

  assign end_match = (state_q == StRun) && (pc == END_PC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pc_valid) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // The budget trips on the cycle whose increment reaches all-ones, so exactly
        // 2^TIMEOUT_W-1 RUN cycles elapse; an end match in that cycle takes priority.
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (end_match) begin
          state_d = StRd;
        end else if (cnt_d == CntMax) begin
          state_d = StTout;
        end else if (!pc_valid) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StRd:   state_d = StWait;
      StWait: state_d = StOut;
      StOut: begin
        if (seq_hs) begin
          state_d = seq_last ? StDone : StRd;
        end
      end
      StDone: state_d = StDone;
      StTout: state_d = StTout;
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold is combinational from the match so the core stalls on the matching fetch.
  assign cpu_hold    = end_match || !(state_q inside {StIdle, StRun});
  assign done        = (state_q == StDone);
  assign timeout     = (state_q == StTout);
  assign cycle_count = cnt_q;

  dump_sequencer #(
    .DMEM_AW   (DMEM_AW),
    .DATA_W    (DATA_W),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_COUNT(DUMP_COUNT),
    .IDX_W     (IdxW)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .state   (state_q),
    .bus     (bus),
    .hs      (seq_hs),
    .last    (seq_last)
`ifdef DUMP_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

endmodule
